// File: rtl/csr_trap_ctrl.sv
// ----------------------------------------------------------------------------
// csr_trap_ctrl
//
// Machine-mode CSR file and trap/return sequencer for the rv32i core.
// Owns the single CSR write port and shares it between CSR instructions
// and the multi-cycle trap-entry / MRET sequences. While a sequence runs
// the pipeline is stalled. Each sequence ends with a one-cycle PC redirect.
//
// Implemented CSRs:
//   0x300 mstatus  : only MIE (bit 3) and MPIE (bit 7) exist; other bits read 0
//   0x305 mtvec    : bits [1:0] read 0
//   0x340 mscratch : full 32 bits
//   0x341 mepc     : bits [1:0] read 0
//   0x342 mcause   : full 32 bits
//   Any other address reads 0, and writes to it are ignored.
//
// Ports:
//   clk            in   system clock; all state changes on the rising edge
//   rst            in   asynchronous, active-high reset
//   csr_w          in   CSR write request from the decoder
//   csr_inm        in   1: write data is zero-extended csr_zimm; 0: csr_wdata
//   csr_addr       in   CSR address, used for both read and write
//   csr_wdata      in   register-source write data
//   csr_zimm       in   5-bit immediate write data
//   csr_rdata      out  combinational read of csr_addr
//   instr_pc       in   PC of the instruction in execute
//   trap_req       in   synchronous exception from execute
//   trap_cause     in   cause code that goes with trap_req
//   mret_req       in   MRET in execute
//   irq_ext        in   level-sensitive machine external interrupt
//   stall          out  hold the pipeline
//   redirect_valid out  one-cycle PC redirect strobe
//   redirect_pc    out  redirect target; 0 when no redirect
// ----------------------------------------------------------------------------
module csr_trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_w,
    input  logic        csr_inm,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [4:0]  csr_zimm,
    output logic [31:0] csr_rdata,
    input  logic [31:0] instr_pc,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic        mret_req,
    input  logic        irq_ext,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // Sequencer states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_T_EPC   = 3'd1;
    localparam logic [2:0] S_T_CAUSE = 3'd2;
    localparam logic [2:0] S_T_JUMP  = 3'd3;
    localparam logic [2:0] S_M_JUMP  = 3'd4;

    // CSR addresses
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

    // Cause code recorded for the machine external interrupt
    localparam logic [31:0] IRQ_EXT_CAUSE = 32'h8000_000B;

    logic [2:0]  state;
    logic [2:0]  state_next;

    // CSR storage. The always-zero low bits of mtvec and mepc are not kept.
    logic        mie;
    logic        mpie;
    logic [29:0] mtvec_hi;
    logic [31:0] mscratch;
    logic [29:0] mepc_hi;
    logic [31:0] mcause;

    // Values captured when a trap is accepted; the requester drops its
    // request once the pipeline stalls, so they must be held here.
    logic [29:0] hold_pc;
    logic [31:0] hold_cause;

    logic        idle;
    logic        irq_pending;
    logic        take_trap;
    logic        take_mret;
    logic        csr_wr_en;
    logic [31:0] csr_wr_data;

    logic        hit_mstatus;
    logic        hit_mtvec;
    logic        hit_mscratch;
    logic        hit_mepc;
    logic        hit_mcause;

    // instr_pc[1:0] is never needed: mepc drops those bits.
    logic        unused_pc_bits;
    assign unused_pc_bits = ^instr_pc[1:0];

    // ------------------------------------------------------------------
    // Event arbitration in IDLE.
    // Priority: trap_req > mret_req > enabled interrupt > CSR write.
    // ------------------------------------------------------------------
    assign idle        = (state == S_IDLE);
    assign irq_pending = irq_ext & mie;
    assign take_trap   = idle & (trap_req | (~mret_req & irq_pending));
    assign take_mret   = idle & ~trap_req & mret_req;
    assign csr_wr_en   = idle & csr_w & ~trap_req & ~mret_req & ~irq_pending;

    assign csr_wr_data = csr_inm ? {27'd0, csr_zimm} : csr_wdata;

    assign hit_mstatus  = (csr_addr == ADDR_MSTATUS);
    assign hit_mtvec    = (csr_addr == ADDR_MTVEC);
    assign hit_mscratch = (csr_addr == ADDR_MSCRATCH);
    assign hit_mepc     = (csr_addr == ADDR_MEPC);
    assign hit_mcause   = (csr_addr == ADDR_MCAUSE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (take_trap) begin
                    state_next = S_T_EPC;
                end else if (take_mret) begin
                    state_next = S_M_JUMP;
                end
            end
            S_T_EPC:   state_next = S_T_CAUSE;
            S_T_CAUSE: state_next = S_T_JUMP;
            S_T_JUMP:  state_next = S_IDLE;
            S_M_JUMP:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Trap capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pc    <= 30'd0;
            hold_cause <= 32'd0;
        end else if (take_trap) begin
            hold_pc    <= instr_pc[31:2];
            hold_cause <= trap_req ? trap_cause : IRQ_EXT_CAUSE;
        end
    end

    // ------------------------------------------------------------------
    // CSR write port. Instruction writes happen only in IDLE and sequence
    // updates only outside IDLE, so the two never collide.
    // ------------------------------------------------------------------

    // mstatus: trap entry stacks MIE into MPIE and disables interrupts;
    // MRET restores MIE from MPIE and sets MPIE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie  <= 1'b0;
            mpie <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (csr_wr_en && hit_mstatus) begin
                        mie  <= csr_wr_data[3];
                        mpie <= csr_wr_data[7];
                    end
                end
                S_T_JUMP: begin
                    mpie <= mie;
                    mie  <= 1'b0;
                end
                S_M_JUMP: begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec_hi <= MTVEC_RESET[31:2];
        end else if (csr_wr_en && hit_mtvec) begin
            mtvec_hi <= csr_wr_data[31:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mscratch <= 32'd0;
        end else if (csr_wr_en && hit_mscratch) begin
            mscratch <= csr_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_hi <= 30'd0;
        end else if (state == S_T_EPC) begin
            mepc_hi <= hold_pc;
        end else if (csr_wr_en && hit_mepc) begin
            mepc_hi <= csr_wr_data[31:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcause <= 32'd0;
        end else if (state == S_T_CAUSE) begin
            mcause <= hold_cause;
        end else if (csr_wr_en && hit_mcause) begin
            mcause <= csr_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Combinational CSR read
    // ------------------------------------------------------------------
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            ADDR_MSTATUS:  csr_rdata = {24'd0, mpie, 3'd0, mie, 3'd0};
            ADDR_MTVEC:    csr_rdata = {mtvec_hi, 2'b00};
            ADDR_MSCRATCH: csr_rdata = mscratch;
            ADDR_MEPC:     csr_rdata = {mepc_hi, 2'b00};
            ADDR_MCAUSE:   csr_rdata = mcause;
            default:       csr_rdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs. A request seen in IDLE stalls in the same
    // cycle so the requester holds its instruction; a plain CSR write
    // completes in one cycle and needs no stall.
    // ------------------------------------------------------------------
    assign stall = ~idle | trap_req | mret_req | irq_pending;

    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (state)
            S_T_JUMP: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mtvec_hi, 2'b00};
            end
            S_M_JUMP: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mepc_hi, 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csr_trap_ctrl
//
// Directed testbench for csr_trap_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled a few ns later, well away from the next edge.
// mtvec reset value is overridden to 32'h0000_0207 so the reset masking of
// bits [1:0] is visible (expected read 32'h0000_0204).
// ----------------------------------------------------------------------------
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_w = 1'b0;
    logic        csr_inm = 1'b0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic [4:0]  csr_zimm = 5'd0;
    logic [31:0] csr_rdata;
    logic [31:0] instr_pc = 32'd0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = 32'd0;
    logic        mret_req = 1'b0;
    logic        irq_ext = 1'b0;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    csr_trap_ctrl #(
        .MTVEC_RESET(32'h0000_0207)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_w         (csr_w),
        .csr_inm       (csr_inm),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_zimm      (csr_zimm),
        .csr_rdata     (csr_rdata),
        .instr_pc      (instr_pc),
        .trap_req      (trap_req),
        .trap_cause    (trap_cause),
        .mret_req      (mret_req),
        .irq_ext       (irq_ext),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic outs(input string tag, input logic s, input logic rv, input logic [31:0] rpc);
        #1;
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
        chk({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, "_rpc"}, redirect_pc, rpc);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_w     = 1'b1;
        csr_inm   = 1'b0;
        csr_addr  = a;
        csr_wdata = d;
        tick;
        csr_w     = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        outs("rst", 1'b0, 1'b0, 32'd0);
        rd(12'h305, 32'h0000_0204, "rst_mtvec");
        rd(12'h300, 32'd0, "rst_mstatus");
        rst = 1'b0;
        tick;

        // CSR instruction writes
        csr_w = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_1003;
        #1;
        chk("csrw_nostall", {31'd0, stall}, 32'd0);
        chk("csrw_sameold", csr_rdata, 32'h0000_0204);
        tick;
        csr_w = 1'b0;
        rd(12'h305, 32'h0000_1000, "mtvec_wr");

        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300, 32'h0000_0088, "mstatus_mask");
        wr(12'h300, 32'h0000_0000);

        csr_w = 1'b1; csr_inm = 1'b1; csr_addr = 12'h340;
        csr_zimm = 5'h1F; csr_wdata = 32'hDEAD_BEEF;
        tick;
        csr_w = 1'b0; csr_inm = 1'b0;
        rd(12'h340, 32'h0000_001F, "mscratch_zimm");

        wr(12'h7C0, 32'hFFFF_FFFF);
        rd(12'h7C0, 32'd0, "unmapped");
        wr(12'h341, 32'h0000_1237);
        rd(12'h341, 32'h0000_1234, "mepc_mask");
        wr(12'h342, 32'h0000_0005);
        rd(12'h342, 32'h0000_0005, "mcause_wr");

        // Trap entry with a concurrent CSR write that must be dropped
        wr(12'h305, 32'h0000_0100);
        wr(12'h300, 32'h0000_0008);
        trap_req = 1'b1; instr_pc = 32'h0000_2004; trap_cause = 32'd11;
        csr_w = 1'b1; csr_addr = 12'h340; csr_wdata = 32'h0000_AAAA;
        outs("trapT0", 1'b1, 1'b0, 32'd0);
        tick;
        trap_req = 1'b0; csr_w = 1'b0;
        instr_pc = 32'hFFFF_FFF0; trap_cause = 32'h99;
        outs("trapT1", 1'b1, 1'b0, 32'd0);
        tick;
        outs("trapT2", 1'b1, 1'b0, 32'd0);
        rd(12'h341, 32'h0000_2004, "trap_mepc");
        rd(12'h342, 32'h0000_0005, "trap_mcause_old");
        tick;
        outs("trapT3", 1'b1, 1'b1, 32'h0000_0100);
        rd(12'h342, 32'd11, "trap_mcause");
        tick;
        outs("trapT4", 1'b0, 1'b0, 32'd0);
        rd(12'h340, 32'h0000_001F, "trap_mscratch");
        rd(12'h300, 32'h0000_0080, "trap_mstatus");

        // MRET
        mret_req = 1'b1;
        outs("mretT0", 1'b1, 1'b0, 32'd0);
        tick;
        mret_req = 1'b0;
        outs("mretT1", 1'b1, 1'b1, 32'h0000_2004);
        tick;
        outs("mretT2", 1'b0, 1'b0, 32'd0);
        rd(12'h300, 32'h0000_0088, "mret_mstatus");

        // External interrupt gated by MIE
        wr(12'h300, 32'h0000_0000);
        rd(12'h300, 32'd0, "irq_mie0");
        irq_ext = 1'b1;
        outs("irq_off0", 1'b0, 1'b0, 32'd0);
        tick;
        outs("irq_off1", 1'b0, 1'b0, 32'd0);
        csr_w = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h0000_0008;
        #1;
        chk("irq_en_nostall", {31'd0, stall}, 32'd0);
        tick;
        csr_w = 1'b0; instr_pc = 32'h0000_3000;
        outs("irqT0", 1'b1, 1'b0, 32'd0);
        tick;
        instr_pc = 32'd0;
        outs("irqT1", 1'b1, 1'b0, 32'd0);
        tick;
        outs("irqT2", 1'b1, 1'b0, 32'd0);
        tick;
        outs("irqT3", 1'b1, 1'b1, 32'h0000_0100);
        tick;
        outs("irqT4", 1'b0, 1'b0, 32'd0);
        rd(12'h342, 32'h8000_000B, "irq_mcause");
        rd(12'h341, 32'h0000_3000, "irq_mepc");
        rd(12'h300, 32'h0000_0080, "irq_mstatus");
        tick;
        outs("irq_noretrap", 1'b0, 1'b0, 32'd0);
        irq_ext = 1'b0;

        // trap_req and mret_req together: trap wins
        trap_req = 1'b1; mret_req = 1'b1;
        instr_pc = 32'h0000_4000; trap_cause = 32'd2;
        tick;
        trap_req = 1'b0; mret_req = 1'b0;
        outs("both_T1", 1'b1, 1'b0, 32'd0);
        tick;
        outs("both_T2", 1'b1, 1'b0, 32'd0);
        tick;
        outs("both_T3", 1'b1, 1'b1, 32'h0000_0100);
        tick;
        rd(12'h341, 32'h0000_4000, "both_mepc");
        rd(12'h342, 32'd2, "both_mcause");

        // trap_req during M_JUMP is ignored
        mret_req = 1'b1;
        tick;
        mret_req = 1'b0;
        trap_req = 1'b1; instr_pc = 32'h0000_5000; trap_cause = 32'd3;
        outs("mj_trap", 1'b1, 1'b1, 32'h0000_4000);
        tick;
        trap_req = 1'b0;
        outs("mj_after0", 1'b0, 1'b0, 32'd0);
        tick;
        outs("mj_after1", 1'b0, 1'b0, 32'd0);
        tick;
        outs("mj_after2", 1'b0, 1'b0, 32'd0);
        rd(12'h341, 32'h0000_4000, "mj_mepc");
        rd(12'h342, 32'd2, "mj_mcause");

        // Reset in the middle of a trap (during T_CAUSE)
        wr(12'h340, 32'h1234_5678);
        trap_req = 1'b1; instr_pc = 32'h0000_6000; trap_cause = 32'd7;
        tick;
        trap_req = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        outs("rstmid", 1'b0, 1'b0, 32'd0);
        rd(12'h341, 32'd0, "rstmid_mepc");
        rd(12'h342, 32'd0, "rstmid_mcause");
        rd(12'h305, 32'h0000_0204, "rstmid_mtvec");
        tick;
        rd(12'h300, 32'd0, "rstmid_mstatus");
        rd(12'h340, 32'd0, "rstmid_mscratch");
        outs("rstmid_c1", 1'b0, 1'b0, 32'd0);
        tick;
        outs("rstmid_c2", 1'b0, 1'b0, 32'd0);
        tick;
        outs("rstmid_c3", 1'b0, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
